// File: rtl/trng_reader.sv
// Pulls fixed-size blocks from a random-bit generator, screens each block with a
// repetition/stuck-at health test, and streams passing blocks out as words, oldest bits first.
module trng_reader #(
  parameter int BLOCK_WIDTH = 1024,
  parameter int WORD_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable_i,
  output logic                   en_o,
  input  logic [BLOCK_WIDTH-1:0] blk_data_i,
  input  logic                   blk_valid_i,
  output logic [WORD_WIDTH-1:0]  word_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic                   rep_err_o,
  input  logic                   clr_err_i,
  output logic [15:0]            blk_cnt_o,
  output logic                   busy_o
);

  localparam int NUM_WORDS = BLOCK_WIDTH / WORD_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, RELEASE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   en_q, en_d;
  logic [WORD_WIDTH-1:0]  word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [15:0]            cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   have_prev_q, have_prev_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [BLOCK_WIDTH-1:0] buf_q, buf_d;
  logic [BLOCK_WIDTH-1:0] prev_q, prev_d;
  logic                   pass_q, pass_d;

  logic [WORD_WIDTH-1:0]  words [NUM_WORDS];
  logic [IDX_W-1:0]       idx_inc;
  logic                   blk_fail;

  // Word 0 is the most significant slice: the oldest bits leave first.
  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign words[gi] = buf_q[BLOCK_WIDTH-1-gi*WORD_WIDTH -: WORD_WIDTH];
    end
  endgenerate

  assign idx_inc  = idx_q + 1'b1;
  assign blk_fail = (blk_data_i == '0) || (&blk_data_i) ||
                    (have_prev_q && (blk_data_i == prev_q));

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    have_prev_d = have_prev_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    prev_d      = prev_q;
    pass_d      = pass_q;

    if (clr_err_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (blk_valid_i) begin
          buf_d       = blk_data_i;
          prev_d      = blk_data_i;
          have_prev_d = 1'b1;
          pass_d      = !blk_fail;
          if (blk_fail) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Hold off until the generator has seen en_o low and withdrawn its block.
        if (!blk_valid_i) begin
          if (pass_q) begin
            state_d = DRAIN;
            idx_d   = '0;
            word_d  = words[0];
          end else begin
            state_d = enable_i ? FETCH : IDLE;
          end
        end
      end
      DRAIN: begin
        if (word_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = enable_i ? FETCH : IDLE;
            idx_d   = '0;
          end else begin
            idx_d  = idx_inc;
            word_d = words[idx_inc];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    en_d    = (state_d == FETCH);
    valid_d = (state_d == DRAIN);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      en_q        <= 1'b0;
      word_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      have_prev_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      word_q      <= word_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      have_prev_q <= have_prev_d;
      idx_q       <= idx_d;
    end
  end

  // Data registers are only ever read behind have_prev_q / pass_q, so they need no reset.
  always_ff @(posedge clk) begin
    buf_q  <= buf_d;
    prev_q <= prev_d;
    pass_q <= pass_d;
  end

  assign en_o         = en_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  assign rep_err_o    = err_q;
  assign blk_cnt_o    = cnt_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/trng_reader.md
TRNG_READER -- requirements
Module: trng_reader

Interface
REQ-001 Parameter BLOCK_WIDTH, default 1024: width of one generator block.
REQ-002 Parameter WORD_WIDTH, default 32: width of one output word; BLOCK_WIDTH SHALL be an integer multiple of WORD_WIDTH and WORD_WIDTH >= 8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 enable_i  input  1  high = keep fetching blocks from the generator.
REQ-006 en_o  output  1  generation enable to the block generator.
REQ-007 blk_data_i  input  BLOCK_WIDTH  generator block data; bit 0 is the newest bit.
REQ-008 blk_valid_i  input  1  generator block valid; held while en_o high, drops one cycle after en_o falls.
REQ-009 word_o  output  WORD_WIDTH  current output word.
REQ-010 word_valid_o  output  1  word_o valid.
REQ-011 word_ready_i  input  1  consumer accepts word_o when word_valid_o && word_ready_i.
REQ-012 rep_err_o  output  1  sticky health-test failure flag.
REQ-013 clr_err_i  input  1  clears rep_err_o.
REQ-014 blk_cnt_o  output  16  count of blocks passing the health test, wraps 0xFFFF->0.
REQ-015 busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, RELEASE, DRAIN; all outputs registered.
REQ-017 IDLE: en_o=0; enable_i=1 -> FETCH, so en_o is high in the cycle after enable_i is sampled high.
REQ-018 FETCH: en_o=1; enable_i=0 -> IDLE with en_o=0 next cycle, no capture; else blk_valid_i=1 -> capture blk_data_i into the block buffer, run the health test, go to RELEASE.
REQ-019 Health test at capture: fail if block is all-zero, all-one, or, when a previous block exists, bitwise equal to the previous captured block; the previous-block register SHALL be updated with every captured block, pass or fail.
REQ-020 Pass: blk_cnt_o increments by 1 in the cycle after capture. Fail: rep_err_o=1 in the cycle after capture, the block is discarded, and no words are emitted.
REQ-021 RELEASE: en_o=0; wait until blk_valid_i=0; then, if the block passed, go to DRAIN; if it failed, go to FETCH when enable_i=1, else IDLE.
REQ-022 DRAIN: emit BLOCK_WIDTH/WORD_WIDTH words, oldest bits first; word k = buffer[BLOCK_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH].
REQ-023 word_valid_o SHALL stay high and word_o stable until accepted; on acceptance, the next word is presented in the next cycle with no bubble; word_ready_i is ignored while word_valid_o=0.
REQ-024 After the last word is accepted: word_valid_o=0 next cycle; go to FETCH if enable_i=1, else IDLE.
REQ-025 enable_i falling during RELEASE or DRAIN SHALL NOT abort; the current block completes.
REQ-026 en_o SHALL never be high in the same cycle as word_valid_o.
REQ-027 clr_err_i=1 clears rep_err_o next cycle; a simultaneous new failure wins (rep_err_o stays 1).
REQ-028 Word index counter width = clog2(BLOCK_WIDTH/WORD_WIDTH), minimum 1 bit, with no wrap beyond the last word.

Reset
REQ-029 rst_n=0 sampled at a clock edge: state=IDLE, en_o=0, word_valid_o=0, word_o=0, rep_err_o=0, blk_cnt_o=0, busy_o=0, previous-block-exists flag cleared, word index=0.
REQ-030 Reset asserted mid-FETCH or mid-DRAIN SHALL abandon the block; after release, the first block is never compared against pre-reset data.

Verification (BLOCK_WIDTH=64, WORD_WIDTH=16, generator model per REQ-008)
REQ-031 enable_i=1, block 0x0123456789ABCDEF, word_ready_i=1 -> en_o high, then low after capture; words 0x0123, 0x4567, 0x89AB, 0xCDEF on consecutive cycles; blk_cnt_o=1.
REQ-032 Same block, word_ready_i low for 3 cycles on word 1 -> 0x4567 held stable for 4 cycles; no word lost or duplicated.
REQ-033 Two consecutive identical blocks 0xA5A5A5A5A5A5A5A5 -> first block emitted; second produces no words, rep_err_o=1, blk_cnt_o stays 1; clr_err_i pulse -> rep_err_o=0.
REQ-034 Block 0x0 on the first fetch after reset -> rep_err_o=1, no words; next block 0x1 passes.
REQ-035 enable_i dropped in FETCH before blk_valid_i -> IDLE, en_o=0, no words; enable_i dropped during DRAIN -> all 4 words emitted, then IDLE.
REQ-036 rst_n=0 after word 1 of 4 -> all outputs at REQ-029 values the next cycle; after release, an identical block passes.
